wrr_table_scheduler: RTL
========================

// Module: wrr_table_scheduler
// PURPOSE
//  Table-driven weighted round-robin scheduler for the 4 QoS queues in front of the PCIe TX mux.
//  Walks a 16-slot arbitration table; each slot names a queue ID.
//  Grants a requesting queue for a burst of (weight+1) packets, then advances the slot pointer.
//  Drives the one-hot grant vector and the 2-bit queue select consumed by the round-robin datapath mux.
// PARAMETERS
//  NUM_Q      4   number of queues; fixed, queue ID is 2 bits
//  NUM_SLOTS  16  table slots; table input is 2*NUM_SLOTS bits wide
//  W_BITS     2   per-queue weight width; burst length = weight+1 (1..4 packets)
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  reset      in   1   synchronous, active-high reset
//  enb        in   1   scheduler enable; 0 = idle and no grants
//  req        in   4   per-queue request; bit q = queue q has a packet ready
//  table      in   32  slot s queue ID = table[2s+1:2s]; read live at each lookup
//  weight     in   8   weight of queue q = weight[2q+1:2q]
//  pkt_done   in   1   one-cycle pulse from datapath: granted packet fully transferred
//  gnt        out  4   one-hot grant, registered; 0 when no grant
//  gnt_vld    out  1   registered, equals |gnt
//  sel        out  2   queue ID of current/last grant; holds value when gnt=0
//  slot_ptr   out  4   current table slot pointer
//  table_miss out  1   one-cycle pulse: 16 consecutive slots scanned with req!=0 and no hit
// BEHAVIOUR
//  Reset: state=IDLE, slot_ptr=0, gnt=0, gnt_vld=0, sel=0, credit=0, miss_cnt=0, table_miss=0.
//  FSM has 3 states: IDLE, SCAN, GRANT.
//  IDLE
//   - enb=1 and req!=0 -> SCAN next cycle.
//  SCAN: one slot per cycle, q = table[2*slot_ptr+:2].
//   - req[q]=1 (hit): next cycle GRANT; gnt=1<<q, sel=q, credit=weight[q], miss_cnt=0; slot_ptr unchanged.
//   - req[q]=0 (miss): slot_ptr++ (15 wraps to 0), miss_cnt++.
//   - miss_cnt reaches 15 on a miss: pulse table_miss, clear miss_cnt, return to IDLE.
//   - req==0: return to IDLE, miss_cnt=0.
//  Latency: req rising in IDLE at cycle N with an immediate slot hit -> gnt valid at N+2.
//   Each additional missed slot adds 1 cycle.
//  GRANT: gnt held stable until the burst ends.
//   - pkt_done=1 and credit!=0 and req[q]=1: credit--, stay in GRANT.
//   - pkt_done=1 and (credit==0 or req[q]=0): gnt=0, slot_ptr++, -> SCAN.
//   - req[q] drops with pkt_done=0 (abort): gnt=0, slot_ptr++, -> SCAN.
//   - pkt_done outside GRANT: ignored.
//  Weight and table changes during GRANT do not affect the running burst.
//   They take effect at the next SCAN lookup or hit.
//  enb=0 in any state: next cycle gnt=0, state=IDLE, credit=0; slot_ptr and sel retained.
//   Re-enable resumes the scan at the retained slot_ptr.
//  reset=1 in any state, including mid-burst: all registers return to reset values next edge.
//   reset overrides enb.
//  gnt is always one-hot or zero; gnt_vld==|gnt; sel==onehot2bin(gnt) whenever gnt!=0.
// STRUCTURE
//  Shared package qos_pkg holds:
//   - NUM_Q, NUM_SLOTS, QID_W=2, W_BITS
//   - state encoding localparams ST_IDLE=2'd0, ST_SCAN=2'd1, ST_GRANT=2'd2
//   - function slot_qid(table, ptr)
//  One sub-module, wrr_burst_counter: loads weight, decrements on pkt_done, flags last packet.
//  FSM, slot pointer and miss counter stay in the top module.
// TESTING  (table=32'hB19E6F92 -> slots 0..7 = 2,0,1,2,3,3,2,1; weight=0 unless noted)
//  1. reset 3 cycles, enb=0 -> gnt=0, sel=0, slot_ptr=0.
//     Then enb=1, req=0 for 10 cycles -> state stays IDLE.
//  2. enb=1, req=4'b0001 -> slot0 miss, slot1 hit -> gnt=0001, sel=0, slot_ptr=1 (3 cycles after req).
//     pkt_done -> gnt=0, slot_ptr=2.
//  3. req=4'b0100, weight[5:4]=3 -> gnt=0100 at slot0.
//     3 pkt_done pulses keep gnt; 4th pulse -> gnt=0, slot_ptr=1.
//  4. req=4'b1111, weight=8'hFF -> grant order q2,q0,q1,q2,q3,q3,q2,q1 following slots 0..7.
//     Each burst lasts 4 pkt_done pulses.
//  5. Mid-burst: enb=0 -> gnt=0 next cycle, slot_ptr kept.
//     Separately: reset asserted during GRANT -> all outputs return to reset values.
//  6. table=32'h0 (all slots q0), req=4'b1000 -> table_miss pulses after 16 scan cycles.
//     Then IDLE, then rescan; gnt never asserts.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared QoS scheduler definitions: sizes, FSM state encoding and the slot lookup helper.
package qos_pkg;

  localparam int NUM_Q     = 4;
  localparam int NUM_SLOTS = 16;
  localparam int QID_W     = 2;
  localparam int W_BITS    = 2;
  localparam int PTR_W     = $clog2(NUM_SLOTS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SCAN  = ST_SCAN,
    S_GRANT = ST_GRANT
  } state_t;

  // Queue ID stored in slot ptr; each slot is a 2-bit field packed LSB first.
  function automatic logic [QID_W-1:0] slot_qid(input logic [QID_W*NUM_SLOTS-1:0] tbl,
                                                input logic [PTR_W-1:0]            ptr);
    return tbl[{ptr, 1'b0} +: QID_W];
  endfunction

endpackage

// File: rtl/wrr_burst_counter.sv
// Per-burst packet credit: loaded with the queue weight on a grant, counts down on pkt_done.
module wrr_burst_counter
  import qos_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [W_BITS-1:0] load_val,
  input  logic              dec,
  output logic [W_BITS-1:0] credit,
  output logic              last
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      credit <= '0;
    end else if (load) begin
      credit <= load_val;
    end else if (dec && credit != '0) begin
      credit <= credit - 1'b1;
    end
  end

  assign last = (credit == '0);

endmodule

// File: rtl/wrr_table_scheduler.sv
// Table-driven weighted round-robin scheduler for the 4 QoS queues feeding the PCIe TX mux.
module wrr_table_scheduler
  import qos_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enb,
  input  logic [NUM_Q-1:0]           req,
  input  logic [QID_W*NUM_SLOTS-1:0] slot_table,
  input  logic [W_BITS*NUM_Q-1:0]    weight,
  input  logic                       pkt_done,
  output logic [NUM_Q-1:0]           gnt,
  output logic                       gnt_vld,
  output logic [QID_W-1:0]           sel,
  output logic [PTR_W-1:0]           slot_ptr,
  output logic                       table_miss
);

  state_t             state;
  logic [PTR_W-1:0]   miss_cnt;
  logic [QID_W-1:0]   slot_q;
  logic [W_BITS-1:0]  slot_w;
  logic               slot_hit;
  logic               sel_req;
  logic               burst_load;
  logic               burst_dec;
  logic [W_BITS-1:0]  credit;
  logic               credit_last;

  // Table and weight are sampled live only at lookup; the running burst depends on sel/credit.
  assign slot_q   = slot_qid(slot_table, slot_ptr);
  assign slot_w   = weight[{slot_q, 1'b0} +: W_BITS];
  assign slot_hit = req[slot_q];
  assign sel_req  = req[sel];

  assign burst_load = enb && (state == S_SCAN) && (req != '0) && slot_hit;
  assign burst_dec  = enb && (state == S_GRANT) && pkt_done && sel_req && !credit_last;

  wrr_burst_counter u_burst (
    .clk      (clk),
    .reset    (reset),
    .clear    (!enb),
    .load     (burst_load),
    .load_val (slot_w),
    .dec      (burst_dec),
    .credit   (credit),
    .last     (credit_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      slot_ptr   <= '0;
      miss_cnt   <= '0;
      gnt        <= '0;
      gnt_vld    <= 1'b0;
      sel        <= '0;
      table_miss <= 1'b0;
    end else begin
      table_miss <= 1'b0;
      if (!enb) begin
        // Disable parks the FSM but keeps slot_ptr and sel so the scan resumes in place.
        state    <= S_IDLE;
        gnt      <= '0;
        gnt_vld  <= 1'b0;
        miss_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req != '0) state <= S_SCAN;
          end
          S_SCAN: begin
            if (req == '0) begin
              state    <= S_IDLE;
              miss_cnt <= '0;
            end else if (slot_hit) begin
              state    <= S_GRANT;
              gnt      <= NUM_Q'(1) << slot_q;
              gnt_vld  <= 1'b1;
              sel      <= slot_q;
              miss_cnt <= '0;
            end else begin
              slot_ptr <= slot_ptr + 1'b1;
              if (miss_cnt == PTR_W'(NUM_SLOTS - 1)) begin
                table_miss <= 1'b1;
                miss_cnt   <= '0;
                state      <= S_IDLE;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          S_GRANT: begin
            // Burst ends on the last credited packet or when the granted queue withdraws.
            if (!sel_req || (pkt_done && credit_last)) begin
              state    <= S_SCAN;
              gnt      <= '0;
              gnt_vld  <= 1'b0;
              slot_ptr <= slot_ptr + 1'b1;
            end
          end
          default: begin
            state   <= S_IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
